// File: rtl/rect_plotter.sv
// rtl/rect_plotter.sv - rasterises one filled, clipped rectangle as single-pixel VGA writes
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [2:0] ERASE_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       erase,
  input  logic [7:0] start_x,
  input  logic [6:0] start_y,
  input  logic [4:0] width,
  input  logic [4:0] height,
  input  logic [2:0] color,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  state_t     state;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [4:0] w, h, cx, cy;
  logic [2:0] col;

  logic [4:0] ncx, ncy;
  logic       row_end, last;
  logic [8:0] nx_sum;
  logic [7:0] ny_sum;
  logic [2:0] start_col;

  // Outputs are registered one step ahead: the counters hold the pixel on the
  // bus, and ncx/ncy address the pixel that will be presented next.
  always_comb begin
    row_end   = (cx == w - 5'd1);
    last      = row_end && (cy == h - 5'd1);
    ncx       = row_end ? 5'd0 : cx + 5'd1;
    ncy       = row_end ? cy + 5'd1 : cy;
    nx_sum    = {1'b0, x0} + {4'b0, ncx};
    ny_sum    = {1'b0, y0} + {3'b0, ncy};
    start_col = erase ? ERASE_COLOR : color;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      col        <= '0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (go) begin
            x0         <= start_x;
            y0         <= start_y;
            w          <= width;
            h          <= height;
            col        <= start_col;
            cx         <= '0;
            cy         <= '0;
            vga_x      <= start_x;
            vga_y      <= start_y;
            vga_colour <= start_col;
            busy       <= 1'b1;
            if (width == 5'd0 || height == 5'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAW;
              plot  <= ({1'b0, start_x} < X_LIM) && ({1'b0, start_y} < Y_LIM);
            end
          end
        end
        DRAW: begin
          if (last) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
            vga_x <= x0;
            vga_y <= y0;
          end else begin
            cx    <= ncx;
            cy    <= ncy;
            vga_x <= nx_sum[7:0];
            vga_y <= ny_sum[6:0];
            // Sums are one bit wider than the bus so off-screen pixels never wrap.
            plot  <= (nx_sum < X_LIM) && (ny_sum < Y_LIM);
          end
        end
        DONE: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// tb/tb_rect_plotter.sv - directed bench with a pixel scoreboard for rect_plotter
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       erase = 1'b0;
  logic [7:0] start_x = '0;
  logic [6:0] start_y = '0;
  logic [4:0] width = '0;
  logic [4:0] height = '0;
  logic [2:0] color = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  rect_plotter dut (
    .clk(clk), .reset(reset), .go(go), .erase(erase),
    .start_x(start_x), .start_y(start_y), .width(width), .height(height), .color(color),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int plot_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every plotted pixel must match the oldest expected pixel.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (plot === 1'b1) begin
      pix_t p;
      plot_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_plot_x", int'(vga_x), -1);
      end else begin
        p = exp_q.pop_front();
        chk("sb_x", int'(vga_x), p.x);
        chk("sb_y", int'(vga_y), p.y);
        chk("sb_colour", int'(vga_colour), p.c);
      end
    end
  end

  task automatic push_rect(input int x, input int y, input int w, input int h,
                           input int c, input int n_rows_cols, output int n_vis);
    pix_t p;
    int k;
    n_vis = 0;
    k = 0;
    for (int r = 0; r < h; r++) begin
      for (int cc = 0; cc < w; cc++) begin
        if (k < n_rows_cols && x + cc < 160 && y + r < 120) begin
          p.x = x + cc;
          p.y = y + r;
          p.c = c;
          exp_q.push_back(p);
          n_vis++;
        end
        k++;
      end
    end
  endtask

  task automatic pulse_go(input int x, input int y, input int w, input int h,
                          input int c, input bit er);
    start_x = 8'(x);
    start_y = 7'(y);
    width   = 5'(w);
    height  = 5'(h);
    color   = 3'(c);
    erase   = er;
    go      = 1'b1;
    @(negedge clk);
    go      = 1'b0;
    start_x = 8'($urandom);
    start_y = 7'($urandom);
    width   = 5'($urandom);
    height  = 5'($urandom);
    color   = 3'($urandom);
    erase   = 1'b0;
  endtask

  task automatic run_rect(input int x, input int y, input int w, input int h,
                          input int c, input bit er);
    int n_vis, p0, d0, cyc, exp_len;
    push_rect(x, y, w, h, er ? 0 : c, 1 << 20, n_vis);
    p0 = plot_cnt;
    d0 = done_cnt;
    exp_len = (w == 0 || h == 0) ? 1 : w * h + 1;
    pulse_go(x, y, w, h, c, er);
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rect_done_cycle", cyc, exp_len);
    chk("rect_busy_at_done", int'(busy), 1);
    chk("rect_plot_at_done", int'(plot), 0);
    @(negedge clk);
    chk("rect_idle_busy", int'(busy), 0);
    chk("rect_plot_count", plot_cnt - p0, n_vis);
    chk("rect_done_count", done_cnt - d0, 1);
    chk("rect_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n_vis, p0, d0;

    // Reset held with go asserted
    reset = 1'b0;
    go = 1'b1;
    start_x = 8'd33; start_y = 7'd44; width = 5'd3; height = 5'd3; color = 3'd6;
    repeat (2) @(negedge clk);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), 0);
    reset = 1'b1;
    go = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_plot", int'(plot), 0);

    // Basic 2x2, cycle by cycle
    push_rect(10, 20, 2, 2, 5, 1 << 20, n_vis);
    p0 = plot_cnt;
    pulse_go(10, 20, 2, 2, 5, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("basic_plot", int'(plot), 1);
      chk("basic_busy", int'(busy), 1);
      chk("basic_done_low", int'(done), 0);
      @(negedge clk);
    end
    chk("basic_done", int'(done), 1);
    chk("basic_done_plot", int'(plot), 0);
    chk("basic_done_busy", int'(busy), 1);
    @(negedge clk);
    chk("basic_idle_busy", int'(busy), 0);
    chk("basic_idle_done", int'(done), 0);
    chk("basic_plots", plot_cnt - p0, 4);

    // Degenerate sizes
    run_rect(40, 50, 0, 7, 3, 1'b0);
    run_rect(40, 50, 3, 0, 3, 1'b0);

    // Clipping at the bottom-right corner and against bus-width wrap
    run_rect(158, 118, 4, 3, 2, 1'b0);
    run_rect(250, 10, 10, 2, 4, 1'b0);
    run_rect(5, 126, 3, 3, 1, 1'b0);

    // Erase with a second go while drawing
    push_rect(0, 0, 3, 1, 0, 1 << 20, n_vis);
    p0 = plot_cnt;
    d0 = done_cnt;
    pulse_go(0, 0, 3, 1, 7, 1'b1);
    @(negedge clk);
    go = 1'b1;
    start_x = 8'd90; start_y = 7'd90; width = 5'd5; height = 5'd5; color = 3'd3;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("erase_done", int'(done), 1);
    repeat (4) @(negedge clk);
    chk("erase_plots", plot_cnt - p0, 3);
    chk("erase_dones", done_cnt - d0, 1);
    chk("erase_busy", int'(busy), 0);
    chk("erase_queue", exp_q.size(), 0);

    // Reset in the middle of a 4x4 draw
    push_rect(30, 40, 4, 4, 3, 6, n_vis);
    p0 = plot_cnt;
    d0 = done_cnt;
    pulse_go(30, 40, 4, 4, 3, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst_plot_c6", int'(plot), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_plots", plot_cnt - p0, 6);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_queue", exp_q.size(), 0);
    run_rect(50, 60, 2, 3, 6, 1'b0);

    // A few pseudo-random rectangles
    for (int i = 0; i < 4; i++) begin
      run_rect($urandom_range(100, 255), $urandom_range(80, 127),
               $urandom_range(1, 31), $urandom_range(1, 31),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
